// File: rtl/j_math_pkg.sv
// Shared constants and types for the j_math transform family.
// The forward transform is y = JM_SCALE * x + JM_OFFSET (mod 2^32).
package j_math_pkg;

    localparam int unsigned JM_OFFSET    = 10000;
    localparam int unsigned JM_SCALE     = 3;
    localparam logic [31:0] JM_SCALE_INV = 32'hAAAA_AAAB;
    localparam logic [31:0] JM_MAX_X     = 32'd1431652431;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SEND
    } jm_inv_state_t;

    // Largest x whose forward transform does not wrap, for a given offset.
    function automatic logic [31:0] jm_max_x(input logic [31:0] offset);
        return 32'((33'h0_FFFF_FFFF - {1'b0, offset}) / 33'(JM_SCALE));
    endfunction

endpackage

// File: rtl/jm_serial_mul.sv
// Serial shift-add multiplier: result = operand * MUL_CONST (mod 2^W), W cycles per product.
// The start pulse loads the operand; done marks the final cycle, and result is valid in that cycle.
module jm_serial_mul #(
    parameter int          W         = 32,
    parameter logic [W-1:0] MUL_CONST = 32'hAAAA_AAAB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] operand,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int CNT_W = $clog2(W);

    logic [W-1:0]     mcand;
    logic [W-1:0]     acc;
    logic [W-1:0]     addend;
    logic [W-1:0]     acc_next;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    always_comb begin
        addend   = MUL_CONST[cnt] ? (mcand << cnt) : '0;
        acc_next = acc + addend;
        done     = busy && (cnt == CNT_W'(W - 1));
        result   = acc_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= operand;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/j_math_inv.sv
// AXI-Stream decoder for j_math: x = (y - OFFSET) * SCALE_INV (mod 2^32), one sample in flight.
// Define J_MATH_INV_RANGE_CHECK_EN to add m00_axis_tuser, set when the forward transform of x wraps.
module j_math_inv
    import j_math_pkg::*;
#(
    parameter int          C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned OFFSET                 = JM_OFFSET,
    parameter logic [31:0] SCALE_INV              = JM_SCALE_INV
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    output logic                                  s00_axis_tready,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
`ifdef J_MATH_INV_RANGE_CHECK_EN
    ,
    output logic                                  m00_axis_tuser
`endif
);

`ifdef J_MATH_INV_RANGE_CHECK_EN
    localparam logic [31:0] MAX_X = jm_max_x(32'(OFFSET));
`endif

    jm_inv_state_t state;
    jm_inv_state_t state_next;

    logic        accept;
    logic [31:0] diff;
    logic        mul_done;
    logic [31:0] mul_result;
    logic        last_q;
    logic [3:0]  strb_q;

    assign accept = (state == IDLE) && s00_axis_tvalid;
    assign diff   = s00_axis_tdata - 32'(OFFSET);

    jm_serial_mul #(
        .W         (32),
        .MUL_CONST (SCALE_INV)
    ) u_mul (
        .clk     (s00_axis_aclk),
        .rst_n   (s00_axis_aresetn),
        .start   (accept),
        .operand (diff),
        .done    (mul_done),
        .result  (mul_result)
    );

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs decode the state alone, so m00_axis_tready never reaches s00_axis_tready.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next      = state;
        s00_axis_tready = 1'b0;
        m00_axis_tvalid = 1'b0;
        case (state)
            IDLE: begin
                s00_axis_tready = 1'b1;
                if (s00_axis_tvalid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (mul_done) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                m00_axis_tvalid = 1'b1;
                if (m00_axis_tready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            last_q <= 1'b0;
            strb_q <= '0;
        end else if (accept) begin
            last_q <= s00_axis_tlast;
            strb_q <= s00_axis_tstrb;
        end
    end

    // The output beat is formed only on the CALC->SEND edge, so it stays frozen through any stall.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            m00_axis_tdata <= '0;
            m00_axis_tlast <= 1'b0;
            m00_axis_tstrb <= '0;
        end else if ((state == CALC) && mul_done) begin
            m00_axis_tdata <= mul_result;
            m00_axis_tlast <= last_q;
            m00_axis_tstrb <= strb_q;
        end
    end

`ifdef J_MATH_INV_RANGE_CHECK_EN
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            m00_axis_tuser <= 1'b0;
        end else if ((state == CALC) && mul_done) begin
            m00_axis_tuser <= (mul_result > MAX_X);
        end
    end
`endif

endmodule

// File: tb/tb_j_math_inv.sv
// Directed bench for j_math_inv: decode values, latency, spacing, stall and mid-operation reset.
// Expected x values come from a forward model y = 3*x + 10000 and hand-computed constants.
module tb_j_math_inv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tready;
    logic        m_tready = 1'b0;
    logic        m_tvalid;
    logic        m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
`ifdef J_MATH_INV_RANGE_CHECK_EN
    logic        m_tuser;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] q_y[$];
    logic [31:0] q_x[$];
    logic        q_last[$];
    logic [3:0]  q_strb[$];
    logic        q_user[$];

    j_math_inv dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tstrb   (s_tstrb),
        .s00_axis_tready  (s_tready),
        .m00_axis_tready  (m_tready),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tstrb   (m_tstrb)
`ifdef J_MATH_INV_RANGE_CHECK_EN
        ,
        .m00_axis_tuser   (m_tuser)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic push_x(input logic [31:0] x, input logic last, input logic [3:0] strb);
        q_y.push_back(32'd3 * x + 32'd10000);
        q_x.push_back(x);
        q_last.push_back(last);
        q_strb.push_back(strb);
        q_user.push_back(x > 32'd1431652431);
    endtask

    task automatic push_y(input logic [31:0] y, input logic [31:0] x, input logic last,
                          input logic [3:0] strb, input logic user);
        q_y.push_back(y);
        q_x.push_back(x);
        q_last.push_back(last);
        q_strb.push_back(strb);
        q_user.push_back(user);
    endtask

    // Drives the queued beats back-to-back with downstream always ready; inputs change on negedge.
    task automatic stream_run();
        int n = q_y.size();
        int in_i = 0;
        int out_i = 0;
        int last_acc = 0;
        int acc_edge[$];
        for (int c = 0; (c < n * 40 + 100) && (out_i < n); c++) begin
            @(negedge clk);
            m_tready = 1'b1;
            if (in_i < n) begin
                s_tvalid = 1'b1;
                s_tdata  = q_y[in_i];
                s_tlast  = q_last[in_i];
                s_tstrb  = q_strb[in_i];
            end else begin
                s_tvalid = 1'b0;
            end
            if (s_tvalid && s_tready) begin
                if (in_i > 0) check("accept_gap", 32'(cyc + 1 - last_acc), 32'd34);
                last_acc = cyc + 1;
                acc_edge.push_back(cyc + 1);
                in_i++;
            end
            if (m_tvalid) begin
                if (out_i >= in_i) begin
                    check("spurious_beat", 32'(out_i), 32'(in_i - 1));
                end else begin
                    check("latency", 32'(cyc + 1 - acc_edge[out_i]), 32'd33);
                    check("tdata", m_tdata, q_x[out_i]);
                    check("tlast", 32'(m_tlast), 32'(q_last[out_i]));
                    check("tstrb", 32'(m_tstrb), 32'(q_strb[out_i]));
`ifdef J_MATH_INV_RANGE_CHECK_EN
                    check("tuser", 32'(m_tuser), 32'(q_user[out_i]));
`endif
                end
                out_i++;
            end
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        check("beats_out", 32'(out_i), 32'(n));
        q_y.delete();
        q_x.delete();
        q_last.delete();
        q_strb.delete();
        q_user.delete();
    endtask

    // Presents one beat and returns at the negedge after the accepting edge.
    task automatic send_one(input logic [31:0] y, input logic last, input logic [3:0] strb);
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = y;
        s_tlast  = last;
        s_tstrb  = strb;
        for (int i = 0; (i < 100) && !s_tready; i++) @(negedge clk);
        check("send_ready", 32'(s_tready), 32'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    initial begin
        int stall_hits;
        logic [31:0] x;

        // Reset state
        #12;
        check("rst_s_tready", 32'(s_tready), 32'd1);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_m_tstrb", 32'(m_tstrb), 32'd0);
`ifdef J_MATH_INV_RANGE_CHECK_EN
        check("rst_m_tuser", 32'(m_tuser), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed decodes, including the wrap case y = 0
        push_y(32'd10015, 32'd5, 1'b1, 4'hF, 1'b0);
        push_y(32'd10000, 32'd0, 1'b0, 4'h3, 1'b0);
        push_y(32'd0, 32'd1431652432, 1'b1, 4'h5, 1'b1);
        stream_run();

        // Round trip through the forward model, back-to-back
        push_x(32'd0, 1'b0, 4'h1);
        push_x(32'd1, 1'b1, 4'h2);
        push_x(32'd1431652431, 1'b0, 4'hC);
        for (int i = 0; i < 1000; i++) begin
            x = $urandom_range(32'd1431652431, 32'd0);
            push_x(x, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
        end
        stream_run();

        // Backpressure: hold the beat for 50 cycles in SEND
        m_tready = 1'b0;
        send_one(32'd10021, 1'b1, 4'hA);
        for (int i = 0; (i < 40) && !m_tvalid; i++) @(negedge clk);
        check("stall_valid_rise", 32'(m_tvalid), 32'd1);
        stall_hits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_tvalid && (m_tdata == 32'd7) && m_tlast && (m_tstrb == 4'hA) && !s_tready)
                stall_hits++;
        end
        check("stall_stable_cycles", 32'(stall_hits), 32'd50);
        check("stall_tdata", m_tdata, 32'd7);
        check("stall_s_tready", 32'(s_tready), 32'd0);
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
        check("stall_release_valid", 32'(m_tvalid), 32'd0);
        check("stall_release_ready", 32'(s_tready), 32'd1);

        // Reset in CALC cycle 10 discards the sample
        send_one(32'd10027, 1'b0, 4'hF);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("arst_s_tready", 32'(s_tready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        m_tready = 1'b1;
        stall_hits = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (m_tvalid) stall_hits++;
        end
        m_tready = 1'b0;
        check("arst_no_output", 32'(stall_hits), 32'd0);
        push_x(32'd12, 1'b1, 4'h9);
        stream_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
